// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the instruction/data memory arbiter
// Purpose: FSM state encoding and transaction owner enum used by mem_arbiter
//          and mem_arb_pick.
// Ports:   none (package).
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data/memory bus bundle for mem_arbiter
// Purpose: groups the fetch port, data port and memory port handshakes.
// Ports:   parameter W (address/data width).
//          modport slave  : arbiter side (accepts fetch/data, drives memory).
//          modport master : environment side (requesters and memory).
interface mem_arbiter_if #(
   parameter int W = 32
);
   import mem_pkg::*;

   // fetch port
   logic         if_req_valid;
   logic         if_req_ready;
   logic [W-1:0] if_req_addr;
   logic         if_resp_valid;
   logic         if_resp_ready;
   logic [W-1:0] if_resp_data;
   logic         if_flush;

   // data port
   logic         d_req_valid;
   logic         d_req_ready;
   logic [W-1:0] d_req_addr;
   logic [W-1:0] d_req_wdata;
   logic         d_req_wen;
   logic         d_resp_valid;
   logic         d_resp_ready;
   logic [W-1:0] d_resp_data;

   // memory port
   logic         m_req_valid;
   logic         m_req_ready;
   logic [W-1:0] m_req_addr;
   logic [W-1:0] m_req_wdata;
   logic         m_req_wen;
   logic         m_resp_valid;
   logic [W-1:0] m_resp_data;

   modport slave (
      input  if_req_valid, if_req_addr, if_resp_ready, if_flush,
      output if_req_ready, if_resp_valid, if_resp_data,
      input  d_req_valid, d_req_addr, d_req_wdata, d_req_wen, d_resp_ready,
      output d_req_ready, d_resp_valid, d_resp_data,
      output m_req_valid, m_req_addr, m_req_wdata, m_req_wen,
      input  m_req_ready, m_resp_valid, m_resp_data
   );

   modport master (
      output if_req_valid, if_req_addr, if_resp_ready, if_flush,
      input  if_req_ready, if_resp_valid, if_resp_data,
      output d_req_valid, d_req_addr, d_req_wdata, d_req_wen, d_resp_ready,
      input  d_req_ready, d_resp_valid, d_resp_data,
      input  m_req_valid, m_req_addr, m_req_wdata, m_req_wen,
      output m_req_ready, m_resp_valid, m_resp_data
   );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - grant decision between fetch and data requesters
// Purpose: combinational grant while pick_en is high.
//          Default: data priority; a waiting fetch is forced through once
//          STARVE_MAX consecutive data grants were made while it waited.
//          MEM_ARB_RR_EN defined: strict round-robin, last granted loses ties,
//          no starve counter.
// Ports:   clk, rst (sync, active-high), pick_en (arbiter is in IDLE),
//          if_valid, if_flush, d_valid -> grant_if, grant_d (one-hot or zero).
module mem_arb_pick
   import mem_pkg::*;
#(
   parameter int STARVE_MAX = 8
)(
   input  logic clk,
   input  logic rst,
   input  logic pick_en,
   input  logic if_valid,
   input  logic if_flush,
   input  logic d_valid,
   output logic grant_if,
   output logic grant_d
);

   // a flush in the pick cycle blocks the fetch only
   logic if_elig;
   assign if_elig = if_valid & ~if_flush;

`ifdef MEM_ARB_RR_EN
   owner_t last_q, last_d;

   always_comb begin
      grant_d  = pick_en & d_valid & (~if_elig | (last_q == OWN_IF));
      grant_if = pick_en & if_elig & ~grant_d;
      last_d   = last_q;
      if (grant_d)
         last_d = OWN_D;
      else if (grant_if)
         last_d = OWN_IF;
   end

   always_ff @(posedge clk) begin
      if (rst)
         last_q <= OWN_IF;
      else
         last_q <= last_d;
   end
`else
   localparam int            CW   = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

   logic [CW-1:0] starve_q, starve_d;

   always_comb begin
      grant_d  = pick_en & d_valid & ~((starve_q == SMAX) & if_elig);
      grant_if = pick_en & if_elig & ~grant_d;
      starve_d = starve_q;
      if (grant_if)
         starve_d = '0;
      // counts data grants that overtook a waiting fetch, saturating
      else if (grant_d && if_valid && (starve_q != SMAX))
         starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         starve_q <= '0;
      else
         starve_q <= starve_d;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter of fetch and data onto one memory port
// Purpose: IDLE picks a requester (mem_arb_pick), REQ presents the latched
//          request to memory, WAIT captures the response, HOLD presents it to
//          the owner. A fetch flushed in REQ/WAIT completes to memory and its
//          response is discarded; a flush in HOLD drops the fetch response.
//          Optional macro MEM_ARB_RR_EN selects round-robin arbitration.
// Ports:   clk, rst (sync, active-high), bus (mem_arbiter_if.slave).
// Params:  STARVE_MAX (data grants before a waiting fetch is forced), W (width).
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int STARVE_MAX = 8,
   parameter int W          = 32
)(
   input  logic            clk,
   input  logic            rst,
   mem_arbiter_if.slave    bus
);

   state_t       state_q, state_d;
   owner_t       owner_q, owner_d;
   logic [W-1:0] addr_q, addr_d;
   logic [W-1:0] wdata_q, wdata_d;
   logic [W-1:0] rdata_q, rdata_d;
   logic         wen_q, wen_d;
   logic         stale_q, stale_d;
   logic         m_req_valid_q, m_req_valid_d;
   logic         if_resp_valid_q, if_resp_valid_d;
   logic         d_resp_valid_q, d_resp_valid_d;

   logic pick_en, grant_if, grant_d, if_owner, flush_own;

   // readies are held low during reset even though state is IDLE
   assign pick_en   = (state_q == ST_IDLE) & ~rst;
   assign if_owner  = (owner_q == OWN_IF);
   assign flush_own = if_owner & bus.if_flush;

   mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .clk      (clk),
      .rst      (rst),
      .pick_en  (pick_en),
      .if_valid (bus.if_req_valid),
      .if_flush (bus.if_flush),
      .d_valid  (bus.d_req_valid),
      .grant_if (grant_if),
      .grant_d  (grant_d)
   );

   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      rdata_d         = rdata_q;
      wen_d           = wen_q;
      stale_d         = stale_q;
      m_req_valid_d   = m_req_valid_q;
      if_resp_valid_d = if_resp_valid_q;
      d_resp_valid_d  = d_resp_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (grant_d) begin
               owner_d       = OWN_D;
               addr_d        = bus.d_req_addr;
               wdata_d       = bus.d_req_wdata;
               wen_d         = bus.d_req_wen;
               stale_d       = 1'b0;
               m_req_valid_d = 1'b1;
               state_d       = ST_REQ;
            end else if (grant_if) begin
               owner_d       = OWN_IF;
               addr_d        = bus.if_req_addr;
               wdata_d       = '0;
               wen_d         = 1'b0;
               stale_d       = 1'b0;
               m_req_valid_d = 1'b1;
               state_d       = ST_REQ;
            end
         end
         ST_REQ: begin
            // request is never withdrawn; a flush only marks it stale
            if (flush_own)
               stale_d = 1'b1;
            if (bus.m_req_ready) begin
               m_req_valid_d = 1'b0;
               state_d       = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (flush_own)
               stale_d = 1'b1;
            if (bus.m_resp_valid) begin
               if (stale_q || flush_own) begin
                  stale_d = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  rdata_d = wen_q ? '0 : bus.m_resp_data;
                  state_d = ST_HOLD;
                  if (if_owner)
                     if_resp_valid_d = 1'b1;
                  else
                     d_resp_valid_d = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (if_owner) begin
               if (bus.if_flush || bus.if_resp_ready) begin
                  if_resp_valid_d = 1'b0;
                  state_d         = ST_IDLE;
               end
            end else if (bus.d_resp_ready) begin
               d_resp_valid_d = 1'b0;
               state_d        = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         owner_q         <= OWN_IF;
         addr_q          <= '0;
         wdata_q         <= '0;
         rdata_q         <= '0;
         wen_q           <= 1'b0;
         stale_q         <= 1'b0;
         m_req_valid_q   <= 1'b0;
         if_resp_valid_q <= 1'b0;
         d_resp_valid_q  <= 1'b0;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         addr_q          <= addr_d;
         wdata_q         <= wdata_d;
         rdata_q         <= rdata_d;
         wen_q           <= wen_d;
         stale_q         <= stale_d;
         m_req_valid_q   <= m_req_valid_d;
         if_resp_valid_q <= if_resp_valid_d;
         d_resp_valid_q  <= d_resp_valid_d;
      end
   end

   assign bus.if_req_ready  = grant_if;
   assign bus.d_req_ready   = grant_d;
   assign bus.m_req_valid   = m_req_valid_q;
   assign bus.m_req_addr    = addr_q;
   assign bus.m_req_wdata   = wdata_q;
   assign bus.m_req_wen     = wen_q;
   // a flush in HOLD drops the fetch response in the same cycle
   assign bus.if_resp_valid = if_resp_valid_q & ~bus.if_flush;
   assign bus.if_resp_data  = rdata_q;
   assign bus.d_resp_valid  = d_resp_valid_q;
   assign bus.d_resp_data   = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc_cnt  = 0;
   int   t0;
   logic [1:0] exp_grant;

   mem_arbiter_if #(.W(32)) bus ();

   mem_arbiter #(
      .STARVE_MAX (8),
      .W          (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // entered at a negedge in REQ; leaves at the negedge in HOLD
   task automatic mem_serve(input logic [31:0] rd);
      bus.m_req_ready  = 1'b1;
      cyc();
      bus.m_req_ready  = 1'b0;
      bus.m_resp_valid = 1'b1;
      bus.m_resp_data  = rd;
      cyc();
      bus.m_resp_valid = 1'b0;
      bus.m_resp_data  = '0;
   endtask

   initial begin
      rst               = 1'b1;
      bus.if_req_valid  = 1'b1;
      bus.if_req_addr   = '0;
      bus.if_resp_ready = 1'b0;
      bus.if_flush      = 1'b0;
      bus.d_req_valid   = 1'b1;
      bus.d_req_addr    = '0;
      bus.d_req_wdata   = '0;
      bus.d_req_wen     = 1'b0;
      bus.d_resp_ready  = 1'b0;
      bus.m_req_ready   = 1'b0;
      bus.m_resp_valid  = 1'b0;
      bus.m_resp_data   = '0;
      repeat (2) cyc();
      #1;
      chk("rst_if_ready", bus.if_req_ready, 0);
      chk("rst_d_ready", bus.d_req_ready, 0);
      chk("rst_m_valid", bus.m_req_valid, 0);
      chk("rst_m_addr", bus.m_req_addr, 0);
      chk("rst_if_resp", bus.if_resp_valid, 0);
      chk("rst_d_resp", bus.d_resp_valid, 0);
      bus.if_req_valid = 1'b0;
      bus.d_req_valid  = 1'b0;
      rst = 1'b0;
      cyc();

      // lone fetch, 3-cycle accept to response
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'hBFC0_0000;
      #1;
      chk("fetch_ready", bus.if_req_ready, 1);
      t0 = cyc_cnt;
      cyc();
      bus.if_req_valid = 1'b0;
      bus.m_req_ready  = 1'b1;
      #1;
      chk("fetch_m_valid", bus.m_req_valid, 1);
      chk("fetch_m_addr", bus.m_req_addr, 32'hBFC0_0000);
      chk("fetch_m_wen", bus.m_req_wen, 0);
      cyc();
      bus.m_req_ready  = 1'b0;
      bus.m_resp_valid = 1'b1;
      bus.m_resp_data  = 32'h2408_0001;
      #1;
      chk("fetch_wait_no_resp", bus.if_resp_valid, 0);
      cyc();
      bus.m_resp_valid  = 1'b0;
      bus.if_resp_ready = 1'b1;
      #1;
      chk("fetch_resp_valid", bus.if_resp_valid, 1);
      chk("fetch_resp_data", bus.if_resp_data, 32'h2408_0001);
      chk("fetch_latency", cyc_cnt - t0, 3);
      cyc();
      bus.if_resp_ready = 1'b0;
      #1;
      chk("fetch_resp_done", bus.if_resp_valid, 0);

      // store, REQ stability, HOLD back-pressure, then a load
      bus.d_req_valid = 1'b1;
      bus.d_req_addr  = 32'h8000_0010;
      bus.d_req_wdata = 32'hDEAD_BEEF;
      bus.d_req_wen   = 1'b1;
      #1;
      chk("store_ready", bus.d_req_ready, 1);
      cyc();
      bus.d_req_valid = 1'b0;
      bus.d_req_wen   = 1'b0;
      bus.d_req_wdata = '0;
      #1;
      chk("store_m_valid", bus.m_req_valid, 1);
      chk("store_m_wen", bus.m_req_wen, 1);
      chk("store_m_wdata", bus.m_req_wdata, 32'hDEAD_BEEF);
      chk("store_m_addr", bus.m_req_addr, 32'h8000_0010);
      cyc();
      #1;
      chk("store_m_stable", bus.m_req_valid, 1);
      chk("store_m_wdata_stable", bus.m_req_wdata, 32'hDEAD_BEEF);
      mem_serve(32'h1234_5678);
      bus.d_req_valid = 1'b1;
      bus.d_req_addr  = 32'h0000_0040;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("hold_d_valid", bus.d_resp_valid, 1);
         chk("hold_d_data", bus.d_resp_data, 0);
         chk("hold_no_m_valid", bus.m_req_valid, 0);
         chk("hold_no_grant", bus.d_req_ready, 0);
         cyc();
      end
      bus.d_resp_ready = 1'b1;
      #1;
      chk("hold_release", bus.d_resp_valid, 1);
      cyc();
      bus.d_resp_ready = 1'b0;
      #1;
      chk("after_hold_resp", bus.d_resp_valid, 0);
      chk("after_hold_grant", bus.d_req_ready, 1);
      cyc();
      bus.d_req_valid = 1'b0;
      #1;
      chk("load_m_addr", bus.m_req_addr, 32'h0000_0040);
      chk("load_m_wen", bus.m_req_wen, 0);
      mem_serve(32'hCAFE_F00D);
      #1;
      chk("load_resp_valid", bus.d_resp_valid, 1);
      chk("load_resp_data", bus.d_resp_data, 32'hCAFE_F00D);
      bus.d_resp_ready = 1'b1;
      cyc();
      bus.d_resp_ready = 1'b0;

      // flush during WAIT: response consumed, next grant next cycle
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h0000_1000;
      #1;
      chk("flushw_ready", bus.if_req_ready, 1);
      cyc();
      bus.if_req_valid = 1'b0;
      bus.m_req_ready  = 1'b1;
      cyc();
      bus.m_req_ready = 1'b0;
      bus.if_flush    = 1'b1;
      cyc();
      bus.if_flush     = 1'b0;
      bus.m_resp_valid = 1'b1;
      bus.m_resp_data  = 32'h1111_1111;
      #1;
      chk("flushw_no_resp_wait", bus.if_resp_valid, 0);
      cyc();
      bus.m_resp_valid = 1'b0;
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h0000_2000;
      #1;
      chk("flushw_no_resp_idle", bus.if_resp_valid, 0);
      chk("flushw_next_grant", bus.if_req_ready, 1);
      cyc();
      bus.if_req_valid = 1'b0;
      #1;
      chk("flushw_next_addr", bus.m_req_addr, 32'h0000_2000);
      mem_serve(32'h3333_3333);
      #1;
      chk("fetch2_resp_valid", bus.if_resp_valid, 1);
      chk("fetch2_resp_data", bus.if_resp_data, 32'h3333_3333);

      // flush in HOLD drops the response and returns to IDLE
      bus.if_flush = 1'b1;
      #1;
      chk("holdflush_drop", bus.if_resp_valid, 0);
      cyc();
      bus.if_flush = 1'b0;
      #1;
      chk("holdflush_gone", bus.if_resp_valid, 0);

      // flush in IDLE blocks fetch only
      bus.if_flush     = 1'b1;
      bus.if_req_valid = 1'b1;
      #1;
      chk("idleflush_if_block", bus.if_req_ready, 0);
      bus.d_req_valid = 1'b1;
      bus.d_req_addr  = 32'h0000_0080;
      bus.d_req_wen   = 1'b0;
      #1;
      chk("idleflush_d_grant", bus.d_req_ready, 1);
      cyc();
      bus.if_flush     = 1'b0;
      bus.if_req_valid = 1'b0;
      bus.d_req_valid  = 1'b0;
      bus.m_req_ready  = 1'b1;
      #1;
      chk("idleflush_d_req", bus.m_req_valid, 1);
      chk("idleflush_d_addr", bus.m_req_addr, 32'h0000_0080);
      cyc();

      // reset in WAIT, late response ignored
      bus.m_req_ready = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bus.m_resp_valid = 1'b1;
      bus.m_resp_data  = 32'h0000_0055;
      #1;
      chk("rstwait_m_valid", bus.m_req_valid, 0);
      cyc();
      bus.m_resp_valid = 1'b0;
      #1;
      chk("rstwait_no_d_resp", bus.d_resp_valid, 0);
      chk("rstwait_no_if_resp", bus.if_resp_valid, 0);
      chk("rstwait_no_m_valid", bus.m_req_valid, 0);

      // both requesters valid every cycle
      bus.if_req_valid  = 1'b1;
      bus.if_req_addr   = 32'h0000_0400;
      bus.d_req_valid   = 1'b1;
      bus.d_req_addr    = 32'h0000_0800;
      bus.if_resp_ready = 1'b1;
      bus.d_resp_ready  = 1'b1;
      for (int g = 0; g < 10; g++) begin
         #1;
`ifdef MEM_ARB_RR_EN
         exp_grant = (g % 2 == 0) ? 2'b01 : 2'b10;
`else
         exp_grant = (g == 8) ? 2'b10 : 2'b01;
`endif
         chk($sformatf("contend_grant_%0d", g), {bus.if_req_ready, bus.d_req_ready}, exp_grant);
         cyc();
         mem_serve(32'h0000_0100 + g);
         #1;
         chk($sformatf("contend_owner_%0d", g), {bus.if_resp_valid, bus.d_resp_valid}, exp_grant);
         cyc();
      end
      bus.if_req_valid = 1'b0;
      bus.d_req_valid  = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 8: consecutive data grants after which a waiting fetch is forced through.
REQ-002 Parameter W, default 32: address and data width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 if_req_valid / if_req_ready  in / out  1  fetch request handshake.
REQ-006 if_req_addr  in  W  fetch physical address.
REQ-007 if_resp_valid / if_resp_ready  out / in  1  fetch response handshake.
REQ-008 if_resp_data  out  W  fetched instruction word.
REQ-009 if_flush  in  1  pipeline flush; in-flight fetch becomes stale.
REQ-010 d_req_valid / d_req_ready  in / out  1  data request handshake.
REQ-011 d_req_addr, d_req_wdata  in  W  data address and store data.
REQ-012 d_req_wen  in  1  1=store, 0=load.
REQ-013 d_resp_valid / d_resp_ready  out / in  1  data response handshake; stores also respond.
REQ-014 d_resp_data  out  W  load data, 0 for stores.
REQ-015 m_req_valid / m_req_ready  out / in  1  memory request handshake.
REQ-016 m_req_addr, m_req_wdata  out  W; m_req_wen  out  1  forwarded request fields.
REQ-017 m_resp_valid  in  1; m_resp_data  in  W  memory response, always accepted.

Function
REQ-018 One transaction outstanding; FSM states IDLE, REQ, WAIT, HOLD.
REQ-019 IDLE: arbitrate among valid requesters; data wins unless starve counter equals STARVE_MAX and fetch is valid; winner fields latched; -> REQ next cycle.
REQ-020 if_req_ready / d_req_ready SHALL be 1 only in IDLE for the granted requester (combinational grant), so acceptance is the IDLE-cycle handshake.
REQ-021 REQ: m_req_valid=1 with latched fields, stable until m_req_ready; on handshake -> WAIT.
REQ-022 WAIT: on m_resp_valid capture m_resp_data (0 if store) -> HOLD; if stale fetch, discard and -> IDLE.
REQ-023 HOLD: assert the owner's resp_valid with held data until owner ready; on handshake -> IDLE; new grant no earlier than next cycle.
REQ-024 Starve counter: +1 on each data grant while fetch valid, saturating at STARVE_MAX; cleared on fetch grant.
REQ-025 if_flush while owner is fetch in REQ or WAIT sets stale flag; REQ still completes to memory (no request withdrawal).
REQ-026 if_flush in HOLD with fetch owner drops if_resp_valid that cycle and -> IDLE.
REQ-027 if_flush in IDLE blocks fetch grant that cycle; data grant unaffected; flush never affects a data transaction.
REQ-028 Latency, no stall: request accept to m_req_valid 1 cycle; m_resp_valid to resp_valid 1 cycle.

Reset
REQ-029 rst: state IDLE, stale=0, starve=0, all valid/ready outputs 0, data outputs 0; in-flight transaction abandoned and a late m_resp_valid in IDLE ignored.

Configuration
REQ-030 MEM_ARB_RR_EN defined: IDLE arbitration strict round-robin (last-granted loses ties), starve counter removed; undefined: data-priority with starvation as REQ-019.

Structure
REQ-031 FSM state encoding and owner enum (OWN_IF, OWN_D) SHALL live in the shared mem_pkg package.
REQ-032 Arbitration decision (priority/starve or round-robin) SHALL be sub-module mem_arb_pick; FSM and buffering remain in mem_arbiter.

Verification
REQ-033 Fetch alone, addr 0xBFC00000, m_req_ready=1, response 0x24080001 one cycle later -> if_resp_data 0x24080001, 3 cycles accept-to-resp.
REQ-034 Fetch and load valid every cycle, STARVE_MAX=8 -> fetch granted at latest after 8 data grants; with MEM_ARB_RR_EN, grants alternate.
REQ-035 Store addr 0x80000010 data 0xDEADBEEF -> m_req_wen=1, wdata 0xDEADBEEF; d_resp_data 0.
REQ-036 if_flush during WAIT of fetch -> memory response consumed, if_resp_valid never asserted, next grant 1 cycle later.
REQ-037 d_resp_ready held 0 for 5 cycles in HOLD -> d_resp_valid/data stable, no m_req_valid meanwhile.
REQ-038 rst during WAIT, then m_resp_valid -> no resp_valid on either port; state IDLE.
